// File: rtl/wbcon_exec.sv
// wbcon command executor: turns parsed null/set-address/write/read commands into
// classic Wishbone single transfers and reports one result per command.
module wbcon_exec #(
  parameter int HW_DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_tvalid,
  output logic                     o_cmd_tready,
  input  logic                     i_cmd_op_null,
  input  logic                     i_cmd_op_set_address,
  input  logic                     i_cmd_op_write_word,
  input  logic                     i_cmd_op_read_word,
  input  logic [ADDR_WIDTH-1:0]    i_cmd_addr,
  input  logic [HW_DATA_WIDTH-1:0] i_cmd_hw_data,
  output logic                     o_cres_tvalid,
  input  logic                     i_cres_tready,
  output logic                     o_cres_op_null,
  output logic                     o_cres_op_set_address,
  output logic                     o_cres_op_write_word,
  output logic                     o_cres_op_read_word,
  output logic [HW_DATA_WIDTH-1:0] o_cres_hw_data,
  output logic                     o_cres_bus_err,
  output logic                     o_cres_bus_rty,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [ADDR_WIDTH-1:0]    o_wb_adr,
  output logic [HW_DATA_WIDTH-1:0] o_wb_dat,
  input  logic [HW_DATA_WIDTH-1:0] i_wb_dat,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic                     i_wb_rty
);

  // The timeout counter only ever reaches TIMEOUT_CYCLES-1 before firing.
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                   state_reg, state_next;
  logic [ADDR_WIDTH-1:0]    addr_reg;
  logic [HW_DATA_WIDTH-1:0] wdata_reg;
  logic [HW_DATA_WIDTH-1:0] rdata_reg;
  logic [TMO_W-1:0]         tmo_cnt_reg;
  logic                     op_null_reg, op_set_reg, op_write_reg, op_read_reg;
  logic                     err_reg, rty_reg;

  logic cmd_accept;
  logic dec_write, dec_read, dec_set, dec_null;
  logic tmo_hit, bus_done;

  assign cmd_accept = i_cmd_tvalid && (state_reg == IDLE);
  assign dec_write  = i_cmd_op_write_word;
  assign dec_read   = !i_cmd_op_write_word && i_cmd_op_read_word;
  assign dec_set    = !i_cmd_op_write_word && !i_cmd_op_read_word && i_cmd_op_set_address;
  assign dec_null   = !i_cmd_op_write_word && !i_cmd_op_read_word && !i_cmd_op_set_address
                      && i_cmd_op_null;

  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt_reg == TMO_LAST);
  assign bus_done = i_wb_err || i_wb_rty || i_wb_ack || tmo_hit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (cmd_accept) state_next = (dec_write || dec_read) ? BUS : RESP;
      BUS:  if (bus_done) state_next = RESP;
      RESP: if (i_cres_tready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      tmo_cnt_reg  <= '0;
      op_null_reg  <= 1'b0;
      op_set_reg   <= 1'b0;
      op_write_reg <= 1'b0;
      op_read_reg  <= 1'b0;
      err_reg      <= 1'b0;
      rty_reg      <= 1'b0;
    end else begin
      if (cmd_accept) begin
        op_null_reg  <= dec_null;
        op_set_reg   <= dec_set;
        op_write_reg <= dec_write;
        op_read_reg  <= dec_read;
        wdata_reg    <= i_cmd_hw_data;
        rdata_reg    <= '0;
        err_reg      <= 1'b0;
        rty_reg      <= 1'b0;
        tmo_cnt_reg  <= '0;
        if (dec_set) addr_reg <= i_cmd_addr;
      end
      // Termination priority err > rty > ack; only ack advances the address.
      if (state_reg == BUS) begin
        if (i_wb_err) begin
          err_reg <= 1'b1;
        end else if (i_wb_rty) begin
          rty_reg <= 1'b1;
        end else if (i_wb_ack) begin
          if (op_read_reg) rdata_reg <= i_wb_dat;
          addr_reg <= addr_reg + 1'b1;
        end else if (tmo_hit) begin
          err_reg <= 1'b1;
        end else begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign o_cmd_tready          = (state_reg == IDLE);
  assign o_cres_tvalid         = (state_reg == RESP);
  assign o_cres_op_null        = op_null_reg;
  assign o_cres_op_set_address = op_set_reg;
  assign o_cres_op_write_word  = op_write_reg;
  assign o_cres_op_read_word   = op_read_reg;
  assign o_cres_hw_data        = rdata_reg;
  assign o_cres_bus_err        = err_reg;
  assign o_cres_bus_rty        = rty_reg;
  assign o_wb_cyc              = (state_reg == BUS);
  assign o_wb_stb              = (state_reg == BUS);
  assign o_wb_we               = (state_reg == BUS) && op_write_reg;
  assign o_wb_adr              = addr_reg;
  assign o_wb_dat              = wdata_reg;

endmodule

// File: tb/tb_wbcon_exec.sv
// Scoreboard bench for wbcon_exec: directed commands push expected bus and result
// records; independent monitors compare them against the Wishbone side and cres stream.
module tb_wbcon_exec;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cmd_tvalid = 1'b0;
  logic        o_cmd_tready;
  logic        i_cmd_op_null = 1'b0, i_cmd_op_set_address = 1'b0;
  logic        i_cmd_op_write_word = 1'b0, i_cmd_op_read_word = 1'b0;
  logic [15:0] i_cmd_addr = '0, i_cmd_hw_data = '0;
  logic        o_cres_tvalid;
  logic        i_cres_tready = 1'b1;
  logic        o_cres_op_null, o_cres_op_set_address, o_cres_op_write_word, o_cres_op_read_word;
  logic [15:0] o_cres_hw_data;
  logic        o_cres_bus_err, o_cres_bus_rty;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [15:0] o_wb_adr, o_wb_dat;
  logic [15:0] i_wb_dat = '0;
  logic        i_wb_ack = 1'b0, i_wb_err = 1'b0, i_wb_rty = 1'b0;

  wbcon_exec #(.HW_DATA_WIDTH(16), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_tvalid(i_cmd_tvalid), .o_cmd_tready(o_cmd_tready),
    .i_cmd_op_null(i_cmd_op_null), .i_cmd_op_set_address(i_cmd_op_set_address),
    .i_cmd_op_write_word(i_cmd_op_write_word), .i_cmd_op_read_word(i_cmd_op_read_word),
    .i_cmd_addr(i_cmd_addr), .i_cmd_hw_data(i_cmd_hw_data),
    .o_cres_tvalid(o_cres_tvalid), .i_cres_tready(i_cres_tready),
    .o_cres_op_null(o_cres_op_null), .o_cres_op_set_address(o_cres_op_set_address),
    .o_cres_op_write_word(o_cres_op_write_word), .o_cres_op_read_word(o_cres_op_read_word),
    .o_cres_hw_data(o_cres_hw_data), .o_cres_bus_err(o_cres_bus_err), .o_cres_bus_rty(o_cres_bus_rty),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_rty(i_wb_rty)
  );

  always #5 i_clk = ~i_clk;

  // op field order everywhere: {null, set_address, write_word, read_word}
  typedef struct { logic [3:0] op; logic [15:0] data; logic err; logic rty; } res_t;
  typedef struct { logic [15:0] adr; logic we; logic [15:0] dat; int cycles; } bus_t;
  localparam logic [3:0] OP_NULL = 4'b1000, OP_SET = 4'b0100, OP_WR = 4'b0010, OP_RD = 4'b0001;
  localparam int M_ACK = 0, M_ERRACK = 1, M_RTY = 2, M_SILENT = 3;

  res_t        res_q[$];
  bus_t        bus_q[$];
  int          n_pass = 0, n_total = 0;
  int          slv_mode = M_ACK;
  logic [15:0] slv_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Wishbone slave model and bus-side checker
  bus_t cur_bus;
  bit   in_txn = 0;
  int   cyc_cnt = 0;
  always @(negedge i_clk) begin
    if (o_wb_cyc && !in_txn) begin
      in_txn  = 1;
      cyc_cnt = 0;
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 32'(o_wb_adr), 32'hFFFF_FFFF);
        cur_bus = '{adr: 16'h0, we: 1'b0, dat: 16'h0, cycles: 0};
      end else begin
        cur_bus = bus_q.pop_front();
        $display("bus txn adr=%h we=%b dat=%h", o_wb_adr, o_wb_we, o_wb_dat);
        chk("wb_adr", 32'(o_wb_adr), 32'(cur_bus.adr));
        chk("wb_we", 32'(o_wb_we), 32'(cur_bus.we));
        chk("wb_dat", 32'(o_wb_dat), 32'(cur_bus.dat));
        chk("wb_stb", 32'(o_wb_stb), 32'd1);
      end
    end
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    i_wb_rty = 1'b0;
    if (o_wb_cyc) begin
      cyc_cnt++;
      case (slv_mode)
        M_ACK:    begin i_wb_ack = 1'b1; i_wb_dat = slv_rdata; end
        M_ERRACK: begin i_wb_ack = 1'b1; i_wb_err = 1'b1; end
        M_RTY:    i_wb_rty = 1'b1;
        default:  ;
      endcase
    end else if (in_txn) begin
      in_txn = 0;
      if (cur_bus.cycles > 0) chk("wb_cyc_len", 32'(cyc_cnt), 32'(cur_bus.cycles));
    end
  end

  // Result-stream checker; re-checks every cycle tvalid is held
  res_t cur_res;
  bit   res_active = 0;
  always @(negedge i_clk) begin
    if (i_rst) res_active = 0;
    else if (o_cres_tvalid) begin
      if (!res_active) begin
        if (res_q.size() == 0) begin
          chk("cres_unexpected", 32'(o_cres_tvalid), 32'd0);
          cur_res = '{op: 4'h0, data: 16'h0, err: 1'b0, rty: 1'b0};
        end else begin
          cur_res = res_q.pop_front();
          $display("cres op=%b data=%h err=%b rty=%b",
                   {o_cres_op_null, o_cres_op_set_address, o_cres_op_write_word, o_cres_op_read_word},
                   o_cres_hw_data, o_cres_bus_err, o_cres_bus_rty);
        end
        res_active = 1;
      end
      chk("cres_op", 32'({o_cres_op_null, o_cres_op_set_address, o_cres_op_write_word,
                          o_cres_op_read_word}), 32'(cur_res.op));
      chk("cres_data", 32'(o_cres_hw_data), 32'(cur_res.data));
      chk("cres_err", 32'(o_cres_bus_err), 32'(cur_res.err));
      chk("cres_rty", 32'(o_cres_bus_rty), 32'(cur_res.rty));
      chk("cmd_tready_in_resp", 32'(o_cmd_tready), 32'd0);
      if (i_cres_tready) res_active = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!o_cmd_tready && n < 200) begin step(); n++; end
    if (!o_cmd_tready) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_cmd(input logic [3:0] flags, input logic [15:0] addr, input logic [15:0] data,
                        input int mode, input logic [15:0] rdata, input int hold);
    int n = 0;
    wait_idle();
    slv_mode      = mode;
    slv_rdata     = rdata;
    i_cres_tready = (hold == 0);
    {i_cmd_op_null, i_cmd_op_set_address, i_cmd_op_write_word, i_cmd_op_read_word} = flags;
    i_cmd_addr    = addr;
    i_cmd_hw_data = data;
    i_cmd_tvalid  = 1'b1;
    while (!o_cmd_tready && n < 200) begin step(); n++; end
    step();
    i_cmd_tvalid = 1'b0;
    if (hold > 0) begin
      repeat (hold) step();
      i_cres_tready = 1'b1;
    end
  endtask

  task automatic exp_res(input logic [3:0] op, input logic [15:0] data, input logic err, input logic rty);
    res_q.push_back('{op: op, data: data, err: err, rty: rty});
  endtask

  task automatic exp_bus(input logic [15:0] adr, input logic we, input logic [15:0] dat, input int cycles);
    bus_q.push_back('{adr: adr, we: we, dat: dat, cycles: cycles});
  endtask

  initial begin
    #2;
    chk("rst_tready", 32'(o_cmd_tready), 32'd1);
    chk("rst_tvalid", 32'(o_cres_tvalid), 32'd0);
    chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("rst_adr", 32'(o_wb_adr), 32'd0);
    step();
    i_rst = 1'b0;
    step();

    exp_res(OP_SET, 16'h0, 0, 0);
    do_cmd(OP_SET, 16'h1234, 16'h0, M_ACK, 16'h0, 0);
    exp_bus(16'h1234, 0, 16'h0, 1);  exp_res(OP_RD, 16'hBEEF, 0, 0);
    do_cmd(OP_RD, 16'h0, 16'h0, M_ACK, 16'hBEEF, 0);
    exp_bus(16'h1235, 0, 16'h0, 1);  exp_res(OP_RD, 16'h0042, 0, 0);
    do_cmd(OP_RD, 16'h0, 16'h0, M_ACK, 16'h0042, 0);

    exp_res(OP_SET, 16'h0, 0, 0);
    do_cmd(OP_SET, 16'hFFFF, 16'h0, M_ACK, 16'h0, 0);
    exp_bus(16'hFFFF, 1, 16'hA5A5, 1);  exp_res(OP_WR, 16'h0, 0, 0);
    do_cmd(OP_WR, 16'h0, 16'hA5A5, M_ACK, 16'h0, 0);
    exp_bus(16'h0000, 1, 16'h5A5A, 1);  exp_res(OP_WR, 16'h0, 0, 0);
    do_cmd(OP_WR, 16'h0, 16'h5A5A, M_ACK, 16'h0, 0);

    exp_bus(16'h0001, 1, 16'h1111, 1);  exp_res(OP_WR, 16'h0, 1, 0);
    do_cmd(OP_WR, 16'h0, 16'h1111, M_ERRACK, 16'h0, 0);
    exp_bus(16'h0001, 1, 16'h2222, 1);  exp_res(OP_WR, 16'h0, 0, 1);
    do_cmd(OP_WR, 16'h0, 16'h2222, M_RTY, 16'h0, 0);
    exp_bus(16'h0001, 0, 16'h0, 1);  exp_res(OP_RD, 16'h7777, 0, 0);
    do_cmd(OP_RD, 16'h0, 16'h0, M_ACK, 16'h7777, 0);

    exp_bus(16'h0002, 0, 16'h0, 4);  exp_res(OP_RD, 16'h0, 1, 0);
    do_cmd(OP_RD, 16'h0, 16'h0, M_SILENT, 16'h9999, 0);

    exp_res(4'b0000, 16'h0, 0, 0);
    do_cmd(4'b0000, 16'hAAAA, 16'hFFFF, M_ACK, 16'h0, 10);
    exp_res(OP_NULL, 16'h0, 0, 0);
    do_cmd(OP_NULL, 16'hAAAA, 16'hFFFF, M_ACK, 16'h0, 10);
    exp_bus(16'h0002, 0, 16'h0, 1);  exp_res(OP_RD, 16'h1357, 0, 0);
    do_cmd(OP_RD, 16'h0, 16'h0, M_ACK, 16'h1357, 0);

    // Reset in the middle of a stalled read
    exp_bus(16'h0003, 0, 16'h0, 0);
    do_cmd(OP_RD, 16'h0, 16'h0, M_SILENT, 16'h0, 0);
    step();
    chk("pre_rst_cyc", 32'(o_wb_cyc), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("midrst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("midrst_stb", 32'(o_wb_stb), 32'd0);
    chk("midrst_tvalid", 32'(o_cres_tvalid), 32'd0);
    chk("midrst_tready", 32'(o_cmd_tready), 32'd1);
    step();
    step();
    i_rst = 1'b0;
    step();

    exp_bus(16'h0000, 0, 16'h0, 1);  exp_res(OP_RD, 16'hCAFE, 0, 0);
    do_cmd(OP_RD, 16'h0, 16'h0, M_ACK, 16'hCAFE, 0);
    exp_bus(16'h0001, 1, 16'h3C3C, 1);  exp_res(OP_WR, 16'h0, 0, 0);
    do_cmd(4'b0111, 16'h5555, 16'h3C3C, M_ACK, 16'h0, 0);

    begin
      int n = 0;
      while ((res_q.size() != 0 || bus_q.size() != 0 || !o_cmd_tready) && n < 200) begin
        step();
        n++;
      end
    end
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
